terminal_console: RTL

//   Character-stream front end for the 80x30 text-mode terminal. Takes bytes on a valid/ready

---
 rtl/terminal_console_if.sv | 28 ++
 rtl/terminal_console.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/terminal_console_if.sv
`default_nettype none
// ============================================================================
//  Module   : terminal_console_if
//  Purpose  : Character stream and terminal text-port bundle for the console.
//  Revision : 1.0  initial release
// ============================================================================
interface terminal_console_if #(
    parameter int ADDR_W = 12
);
    logic              char_valid;
    logic [7:0]        char_data;
    logic              char_ready;
    logic [ADDR_W-1:0] text_addr;
    logic              text_write;
    logic [7:0]        text_in;
    logic [7:0]        text_out;

    // master: the console itself; slave: the byte source plus the text buffer
    modport master (
        input  char_valid, char_data, text_out,
        output char_ready, text_addr, text_write, text_in
    );
    modport slave (
        output char_valid, char_data, text_out,
        input  char_ready, text_addr, text_write, text_in
    );
endinterface
`default_nettype wire

// File: rtl/terminal_console.sv
`default_nettype none
// ============================================================================
//  Module   : terminal_console
//  Purpose  : Byte-stream front end for an 80x30 text terminal: cursor,
//             control characters, hardware scroll and screen clear.
//  Revision : 1.0  initial release
// ============================================================================
module terminal_console #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic                clock,
    input  logic                resetn,
    terminal_console_if.master  term,
    output logic                busy,
    output logic [6:0]          cursor_col,
    output logic [4:0]          cursor_row
);
    localparam logic [6:0]        c_LAST_COL      = 7'(COLS - 1);
    localparam logic [4:0]        c_LAST_ROW      = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] c_COLS_A        = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] c_TOTAL         = ADDR_W'(COLS * ROWS);
    localparam logic [ADDR_W-1:0] c_LAST_ROW_BASE = ADDR_W'(COLS * (ROWS - 1));
    localparam logic [ADDR_W-1:0] c_ONE_A         = ADDR_W'(1);
    localparam logic [7:0]        c_SPACE         = 8'h20;

    typedef enum logic [2:0] {
        S_CLEAR   = 3'd0,
        S_IDLE    = 3'd1,
        S_PUT     = 3'd2,
        S_COPY_RD = 3'd3,
        S_COPY_WR = 3'd4,
        S_CLR_ROW = 3'd5
    } state_t;

    state_t            r_state;
    logic [6:0]        r_col;
    logic [4:0]        r_row;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_src;
    logic              r_is_bs;
    logic              r_ready;
    logic              r_busy;
    logic [ADDR_W-1:0] r_text_addr;
    logic              r_text_write;
    logic [7:0]        r_text_in;

    logic [ADDR_W-1:0] w_cur_addr;
    logic [6:0]        w_tab_col;
    logic              w_printable;

    assign w_cur_addr  = ADDR_W'(r_row) * c_COLS_A + ADDR_W'(r_col);
    assign w_tab_col   = (r_col | 7'd7) + 7'd1;
    assign w_printable = (term.char_data >= 8'h20) && (term.char_data <= 8'h7E);

    assign term.char_ready = r_ready;
    assign term.text_addr  = r_text_addr;
    assign term.text_write = r_text_write;
    assign term.text_in    = r_text_in;
    assign busy            = r_busy;
    assign cursor_col      = r_col;
    assign cursor_row      = r_row;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_CLEAR;
            r_col        <= '0;
            r_row        <= '0;
            r_count      <= '0;
            r_src        <= '0;
            r_is_bs      <= 1'b0;
            r_ready      <= 1'b0;
            r_busy       <= 1'b1;
            r_text_addr  <= '0;
            r_text_write <= 1'b0;
            r_text_in    <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    // The extra cycle at r_count==c_TOTAL lets the final write retire before ready rises
                    if (r_count == c_TOTAL) begin
                        r_text_write <= 1'b0;
                        r_col        <= '0;
                        r_row        <= '0;
                        r_ready      <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_text_write <= 1'b1;
                        r_text_addr  <= r_count;
                        r_text_in    <= c_SPACE;
                        r_count      <= r_count + c_ONE_A;
                    end
                end

                S_IDLE: begin
                    r_text_write <= 1'b0;
                    if (term.char_valid) begin
                        if (w_printable) begin
                            r_text_write <= 1'b1;
                            r_text_addr  <= w_cur_addr;
                            r_text_in    <= term.char_data;
                            r_is_bs      <= 1'b0;
                            r_ready      <= 1'b0;
                            r_state      <= S_PUT;
                        end else begin
                            case (term.char_data)
                                8'h0A, 8'h09: begin
                                    if (term.char_data == 8'h09 && w_tab_col <= c_LAST_COL) begin
                                        r_col <= w_tab_col;
                                    end else begin
                                        r_col <= '0;
                                        if (r_row != c_LAST_ROW) begin
                                            r_row <= r_row + 5'd1;
                                        end else begin
                                            r_src       <= c_COLS_A;
                                            r_text_addr <= c_COLS_A;
                                            r_ready     <= 1'b0;
                                            r_busy      <= 1'b1;
                                            r_state     <= S_COPY_RD;
                                        end
                                    end
                                end
                                8'h0D: r_col <= '0;
                                8'h08: begin
                                    if (r_col != 7'd0) begin
                                        r_text_write <= 1'b1;
                                        r_text_addr  <= w_cur_addr - c_ONE_A;
                                        r_text_in    <= c_SPACE;
                                        r_is_bs      <= 1'b1;
                                        r_ready      <= 1'b0;
                                        r_state      <= S_PUT;
                                    end
                                end
                                8'h0C: begin
                                    r_count <= '0;
                                    r_ready <= 1'b0;
                                    r_busy  <= 1'b1;
                                    r_state <= S_CLEAR;
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                S_PUT: begin
                    // Cursor moves only once the write has been presented to the buffer
                    r_text_write <= 1'b0;
                    r_ready      <= 1'b1;
                    r_state      <= S_IDLE;
                    if (r_is_bs) begin
                        r_col <= r_col - 7'd1;
                    end else if (r_col != c_LAST_COL) begin
                        r_col <= r_col + 7'd1;
                    end else begin
                        r_col <= '0;
                        if (r_row != c_LAST_ROW) begin
                            r_row <= r_row + 5'd1;
                        end else begin
                            r_src       <= c_COLS_A;
                            r_text_addr <= c_COLS_A;
                            r_ready     <= 1'b0;
                            r_busy      <= 1'b1;
                            r_state     <= S_COPY_RD;
                        end
                    end
                end

                S_COPY_RD: begin
                    r_text_addr  <= r_src - c_COLS_A;
                    r_text_write <= 1'b1;
                    r_text_in    <= term.text_out;
                    r_state      <= S_COPY_WR;
                end

                S_COPY_WR: begin
                    if (r_src == c_TOTAL - c_ONE_A) begin
                        r_text_addr  <= c_LAST_ROW_BASE;
                        r_text_in    <= c_SPACE;
                        r_text_write <= 1'b1;
                        r_count      <= c_LAST_ROW_BASE + c_ONE_A;
                        r_state      <= S_CLR_ROW;
                    end else begin
                        r_src        <= r_src + c_ONE_A;
                        r_text_addr  <= r_src + c_ONE_A;
                        r_text_write <= 1'b0;
                        r_state      <= S_COPY_RD;
                    end
                end

                S_CLR_ROW: begin
                    if (r_count == c_TOTAL) begin
                        r_text_write <= 1'b0;
                        r_ready      <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_text_write <= 1'b1;
                        r_text_addr  <= r_count;
                        r_text_in    <= c_SPACE;
                        r_count      <= r_count + c_ONE_A;
                    end
                end

                default: begin
                    r_count      <= '0;
                    r_text_write <= 1'b0;
                    r_ready      <= 1'b0;
                    r_busy       <= 1'b1;
                    r_state      <= S_CLEAR;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
